sign_ext: RTL and testbench
===========================

SIGN_EXT -- requirements
Module: sign_ext

Interface
REQ-001 The module SHALL provide parameter n, default 16, input data width in bits (n >= 1).
REQ-002 The module SHALL provide parameter num, default 16, number of extension bits prepended (num >= 1).
REQ-003 The module SHALL provide port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL provide port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The module SHALL provide port in, input, n bits, two's-complement value to extend.
REQ-006 The module SHALL provide port en, input, 1 bit, capture enable.
REQ-007 The module SHALL provide port out, output, n+num bits, registered sign-extended result.
REQ-008 The module SHALL provide port out_valid, output, 1 bit, high when out holds a captured value since the last reset.

Function
REQ-009 Extension rule: the extended value SHALL be num copies of in[n-1] concatenated above in[n-1:0]; out[n-1:0] = in, out[n+num-1:n] = {num{in[n-1]}}.
REQ-010 On a rising clk edge with rst=0 and en=1, out SHALL load the extended value of the current in; latency is one cycle.
REQ-011 On a rising clk edge with rst=0 and en=0, out and out_valid SHALL hold their previous values regardless of in.
REQ-012 out_valid SHALL be set to 1 on the first enabled capture after reset and remain 1 until the next reset.
REQ-013 rst SHALL take priority over en when both are high on the same edge.
REQ-014 Changes to in between clock edges SHALL NOT affect out (no combinational path from in or en to out).
REQ-015 Boundary values SHALL extend exactly: most-negative input yields all-ones upper field; most-positive input yields all-zeros upper field; zero yields zero.
REQ-016 Output width SHALL be computed as n+num with no truncation or overflow for any legal parameter pair.

Reset
REQ-017 While rst=1 at a rising clk edge, out SHALL become all zeros and out_valid SHALL become 0.
REQ-018 Reset SHALL be synchronous only; asserting rst between edges SHALL NOT change outputs until the next rising edge.
REQ-019 Reset asserted mid-stream SHALL discard the held value; the next enabled capture after rst deasserts SHALL behave as the first capture.

Structure
REQ-020 A shared package sign_ext_pkg SHALL hold the default width constants (DEFAULT_N=16, DEFAULT_NUM=16).
REQ-021 The combinational extension of REQ-009 SHALL be a separate sub-module sign_ext_comb (parameters n, num; ports in, out), instantiated once inside sign_ext and followed by the output register.
REQ-022 Parameter legality (n >= 1, num >= 1) SHALL be checked at elaboration with a fatal error on violation.

Verification (n=8, num=4)
REQ-023 rst=1 for one edge with in=8'hFF, en=1 -> out=12'h000, out_valid=0.
REQ-024 rst=0, en=1, in=8'b0111_1111 -> after one edge out=12'b0000_0111_1111, out_valid=1.
REQ-025 rst=0, en=1, in=8'b1000_0000 -> after one edge out=12'b1111_1000_0000.
REQ-026 After capturing 8'h80, drive en=0, in=8'h01 for 3 edges -> out remains 12'hF80.
REQ-027 rst=1 and en=1 on same edge with in=8'hAA -> out=12'h000, out_valid=0; next edge rst=0, en=1 -> out=12'hFAA, out_valid=1.
REQ-028 Exhaustive sweep in=0..255 with en=1, rst=0 -> each cycle out equals in sign-extended to 12 bits, checked against a reference model.

Source files
------------

// File: rtl/sign_ext_pkg.sv
// Shared width defaults and a width helper for the sign extender.
package sign_ext_pkg;

  localparam int DEFAULT_N   = 16;
  localparam int DEFAULT_NUM = 16;

  function automatic int ext_width(input int n, input int num);
    return n + num;
  endfunction

endpackage

// File: rtl/sign_ext_comb.sv
// Combinational sign extension: replicates the top input bit num times above the input.
// Zero latency, no flow control.
module sign_ext_comb
  import sign_ext_pkg::*;
#(
  parameter int n   = DEFAULT_N,
  parameter int num = DEFAULT_NUM
) (
  input  logic [n-1:0]     in,
  output logic [n+num-1:0] out
);

  assign out = {{num{in[n-1]}}, in};

endmodule

// File: rtl/sign_ext.sv
// Registered sign extender: captures the extended input when en is high.
// Latency one cycle; en=0 holds out and out_valid, no backpressure.
module sign_ext
  import sign_ext_pkg::*;
#(
  parameter int n   = DEFAULT_N,
  parameter int num = DEFAULT_NUM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [n-1:0]         in,
  input  logic                 en,
  output logic [n+num-1:0]     out,
  output logic                 out_valid
);

  localparam int W = ext_width(n, num);

  if (n < 1 || num < 1) begin : g_param_check
    $fatal(1, "sign_ext: n and num must both be >= 1");
  end

  logic [W-1:0] ext;
  logic [W-1:0] out_d, out_q;
  logic         out_valid_d, out_valid_q;

  sign_ext_comb #(
    .n   (n),
    .num (num)
  ) u_comb (
    .in  (in),
    .out (ext)
  );

  // Reset wins over a simultaneous capture request.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (rst) begin
      out_d       = '0;
      out_valid_d = 1'b0;
    end else if (en) begin
      out_d       = ext;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    out_q       <= out_d;
    out_valid_q <= out_valid_d;
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_ext.sv
// Directed and table-driven checks of sign_ext at n=8, num=4.
module tb_sign_ext;

  localparam int N   = 8;
  localparam int NUM = 4;
  localparam int W   = N + NUM;

  logic         clk;
  logic         rst;
  logic [N-1:0] in;
  logic         en;
  logic [W-1:0] out;
  logic         out_valid;

  int n_cmp;
  int n_bad;

  sign_ext #(
    .n   (N),
    .num (NUM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .en        (en),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic         en;
    logic [N-1:0] in;
    logic [W-1:0] exp_out;
    logic         exp_vld;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
    end
  endtask

  // Drive inputs just after an edge, then sample 1ns after the next edge.
  task automatic step(input logic r, input logic e, input logic [N-1:0] v);
    rst = r;
    en  = e;
    in  = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_ext(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = W'(v);
    if (v >= 8'd128) r = r + 12'hF00;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    en  = 1'b0;
    in  = '0;

    vecs.push_back('{"reset_ff",    1'b1, 1'b1, 8'hFF, 12'h000, 1'b0});
    vecs.push_back('{"max_pos",     1'b0, 1'b1, 8'h7F, 12'h07F, 1'b1});
    vecs.push_back('{"most_neg",    1'b0, 1'b1, 8'h80, 12'hF80, 1'b1});
    vecs.push_back('{"hold_1",      1'b0, 1'b0, 8'h01, 12'hF80, 1'b1});
    vecs.push_back('{"hold_2",      1'b0, 1'b0, 8'h01, 12'hF80, 1'b1});
    vecs.push_back('{"hold_3",      1'b0, 1'b0, 8'h01, 12'hF80, 1'b1});
    vecs.push_back('{"rst_over_en", 1'b1, 1'b1, 8'hAA, 12'h000, 1'b0});
    vecs.push_back('{"first_after", 1'b0, 1'b1, 8'hAA, 12'hFAA, 1'b1});
    vecs.push_back('{"hold_55",     1'b0, 1'b0, 8'h55, 12'hFAA, 1'b1});
    vecs.push_back('{"zero",        1'b0, 1'b1, 8'h00, 12'h000, 1'b1});
    vecs.push_back('{"pos_55",      1'b0, 1'b1, 8'h55, 12'h055, 1'b1});
    vecs.push_back('{"neg_ff",      1'b0, 1'b1, 8'hFF, 12'hFFF, 1'b1});

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].in);
      chk({vecs[i].name, "_out"}, out, vecs[i].exp_out);
      chk({vecs[i].name, "_vld"}, W'(out_valid), W'(vecs[i].exp_vld));
    end

    // Input changes between edges must not reach out.
    step(1'b0, 1'b1, 8'h12);
    chk("cap_12", out, 12'h012);
    in = 8'hC3;
    #3;
    chk("in_midcycle", out, 12'h012);
    en = 1'b0;
    #1;
    chk("en_midcycle", out, 12'h012);

    // Reset raised between edges takes effect only at the next edge.
    rst = 1'b1;
    #2;
    chk("rst_midcycle_out", out, 12'h012);
    chk("rst_midcycle_vld", W'(out_valid), W'(1'b1));
    @(posedge clk);
    #1;
    chk("rst_edge_out", out, 12'h000);
    chk("rst_edge_vld", W'(out_valid), W'(1'b0));

    // After reset, idle cycles keep out_valid low until the first capture.
    step(1'b0, 1'b0, 8'hC3);
    chk("idle_after_rst_out", out, 12'h000);
    chk("idle_after_rst_vld", W'(out_valid), W'(1'b0));
    step(1'b0, 1'b1, 8'hC3);
    chk("first_cap_out", out, 12'hFC3);
    chk("first_cap_vld", W'(out_valid), W'(1'b1));

    for (int v = 0; v < 256; v++) begin
      step(1'b0, 1'b1, N'(v));
      chk($sformatf("sweep_%02h", v), out, ref_ext(N'(v)));
    end
    chk("sweep_vld", W'(out_valid), W'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
